// File: rtl/dense_layer_sequencer_pkg.sv
// Shared definitions for the time-multiplexed dense layer.
// Holds the FSM state encoding, default layer geometry, the accumulator width
// and a helper that sizes counters/addresses so they never collapse to zero bits.
package dense_layer_sequencer_pkg;

    localparam int unsigned IN_FEATURES_DEF  = 128;
    localparam int unsigned OUT_FEATURES_DEF = 64;
    localparam int unsigned LANES_DEF        = 8;
    localparam int unsigned SHIFT_DEF        = 16;
    localparam int unsigned ACC_W            = 32;

    // Index width for a range of n values; at least one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned GROUPS_DEF = OUT_FEATURES_DEF / LANES_DEF;
    localparam int unsigned W_AW_DEF   = idx_w(GROUPS_DEF * IN_FEATURES_DEF);
    localparam int unsigned B_AW_DEF   = idx_w(GROUPS_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_MAC,
        ST_DRAIN,
        ST_STORE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/dense_layer_sequencer_if.sv
// Bus bundle for dense_layer_sequencer.
//   input vector handshake : in_valid, in_ready, in_data
//   weight RAM read port   : w_rd_en, w_addr, w_rdata (1-cycle latency)
//   bias RAM read port     : b_rd_en, b_addr, b_rdata (1-cycle latency)
//   result handshake       : out_valid, out_ready, out_data
//   status                 : busy
// modport slave is the sequencer; modport master is its environment.
interface dense_layer_sequencer_if
    import dense_layer_sequencer_pkg::*;
#(
    parameter int unsigned IN_FEATURES  = IN_FEATURES_DEF,
    parameter int unsigned OUT_FEATURES = OUT_FEATURES_DEF,
    parameter int unsigned LANES        = LANES_DEF
) ();

    localparam int unsigned GROUPS = OUT_FEATURES / LANES;
    localparam int unsigned W_AW   = idx_w(GROUPS * IN_FEATURES);
    localparam int unsigned B_AW   = idx_w(GROUPS);

    logic                        in_valid;
    logic                        in_ready;
    logic [IN_FEATURES*8-1:0]    in_data;
    logic                        w_rd_en;
    logic [W_AW-1:0]             w_addr;
    logic [LANES*ACC_W-1:0]      w_rdata;
    logic                        b_rd_en;
    logic [B_AW-1:0]             b_addr;
    logic [LANES*ACC_W-1:0]      b_rdata;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_FEATURES*8-1:0]   out_data;
    logic                        busy;

    modport slave (
        input  in_valid, in_data, w_rdata, b_rdata, out_ready,
        output in_ready, w_rd_en, w_addr, b_rd_en, b_addr, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, w_rdata, b_rdata, out_ready,
        input  in_ready, w_rd_en, w_addr, b_rd_en, b_addr, out_valid, out_data, busy
    );

endinterface

// File: rtl/dense_layer_sequencer_mac_lane.sv
// One MAC lane of the dense layer.
//   load     : acc <= load_val (bias)
//   acc_en   : acc <= acc + weight*feature, truncated to ACC_W, wrapping
//   byte_out : requantized byte, acc[SHIFT+7:SHIFT]
// Accumulator holds when neither strobe is set.
module dense_mac_lane
    import dense_layer_sequencer_pkg::*;
#(
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             acc_en,
    input  logic [ACC_W-1:0] load_val,
    input  logic [ACC_W-1:0] weight,
    input  logic [7:0]       feature,
    output logic [7:0]       byte_out
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = load_val;
        end else if (acc_en) begin
            acc_d = acc_q + (weight * ACC_W'(feature));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign byte_out = acc_q[SHIFT+7:SHIFT];

endmodule

// File: rtl/dense_layer_sequencer.sv
// Time-multiplexed fully-connected layer controller/datapath.
// Captures an IN_FEATURES x 8b vector, then for each group of LANES neurons:
// reads the bias word, streams IN_FEATURES weight words from a synchronous RAM
// into LANES MAC lanes, and stores the requantized bytes into the result buffer.
// Ports: clk, rst (synchronous, active-high), bus (dense_layer_sequencer_if.slave).
module dense_layer_sequencer
    import dense_layer_sequencer_pkg::*;
#(
    parameter int unsigned IN_FEATURES  = IN_FEATURES_DEF,
    parameter int unsigned OUT_FEATURES = OUT_FEATURES_DEF,
    parameter int unsigned LANES        = LANES_DEF,
    parameter int unsigned SHIFT        = SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    dense_layer_sequencer_if.slave  bus
);

    localparam int unsigned GROUPS = OUT_FEATURES / LANES;
    localparam int unsigned J_W    = idx_w(IN_FEATURES);
    localparam int unsigned G_W    = idx_w(GROUPS);
    localparam int unsigned W_AW   = idx_w(GROUPS * IN_FEATURES);
    localparam int unsigned B_AW   = idx_w(GROUPS);

    localparam logic [J_W-1:0] J_LAST = J_W'(IN_FEATURES - 1);
    localparam logic [G_W-1:0] G_LAST = G_W'(GROUPS - 1);

    generate
        if ((OUT_FEATURES % LANES) != 0) begin : g_bad_cfg
            $error("OUT_FEATURES must be a multiple of LANES");
        end
    endgenerate

    state_e                    state_q, state_d;
    logic [J_W-1:0]            j_q, j_d;
    logic [G_W-1:0]            group_q, group_d;
    logic [7:0]                in_q [IN_FEATURES];
    logic [7:0]                in_d [IN_FEATURES];
    logic [OUT_FEATURES*8-1:0] out_q, out_d;

    logic       lane_load;
    logic       lane_acc;
    logic [J_W-1:0] fidx;
    logic [7:0] feature;
    logic [7:0] lane_byte [LANES];

    // Control FSM, counters and input capture.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        group_d = group_q;
        in_d    = in_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    for (int unsigned i = 0; i < IN_FEATURES; i++) begin
                        in_d[i] = bus.in_data[i*8 +: 8];
                    end
                    state_d = ST_BIAS;
                end
            end
            ST_BIAS: begin
                j_d     = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                if (j_q == J_LAST) begin
                    j_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_STORE;
            end
            ST_STORE: begin
                if (group_q == G_LAST) begin
                    group_d = '0;
                    state_d = ST_DONE;
                end else begin
                    group_d = group_q + 1'b1;
                    state_d = ST_BIAS;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM data lags the address by one cycle: the first MAC cycle sees the bias,
    // each later MAC cycle sees weight j-1, and DRAIN consumes the last weight.
    always_comb begin
        lane_load = (state_q == ST_MAC) && (j_q == '0);
        lane_acc  = ((state_q == ST_MAC) && (j_q != '0)) || (state_q == ST_DRAIN);
        fidx      = (state_q == ST_DRAIN) ? J_LAST : (j_q - 1'b1);
        feature   = in_q[fidx];
    end

    // Result buffer: one group of bytes written per STORE, others hold.
    always_comb begin
        out_d = out_q;
        if (state_q == ST_STORE) begin
            for (int unsigned g = 0; g < GROUPS; g++) begin
                if (group_q == G_W'(g)) begin
                    for (int unsigned k = 0; k < LANES; k++) begin
                        out_d[(g*LANES + k)*8 +: 8] = lane_byte[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            group_q <= '0;
            in_q    <= '{default: '0};
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            group_q <= group_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            dense_mac_lane #(
                .SHIFT (SHIFT)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .load     (lane_load),
                .acc_en   (lane_acc),
                .load_val (bus.b_rdata[k*ACC_W +: ACC_W]),
                .weight   (bus.w_rdata[k*ACC_W +: ACC_W]),
                .feature  (feature),
                .byte_out (lane_byte[k])
            );
        end
    endgenerate

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = out_q;
    assign bus.w_rd_en   = (state_q == ST_MAC);
    assign bus.w_addr    = (state_q == ST_MAC)
                         ? (W_AW'(group_q) * W_AW'(IN_FEATURES) + W_AW'(j_q))
                         : '0;
    assign bus.b_rd_en   = (state_q == ST_BIAS);
    assign bus.b_addr    = (state_q == ST_BIAS) ? B_AW'(group_q) : '0;

endmodule
